tl_d_resp_arb_fifo: RTL

- Multi-channel TileLink D-channel response buffer for the MPU response path.
- NUM_CH independent FIFOs, each DEPTH entries of tl_d_channel, accept responses from separate producers (e.g. MPU pipes / slave ports).
- A parametrised arbiter (round-robin or fixed priority) merges the FIFOs onto one D-channel output with a proper valid/ready handshake.
- Supersedes the single-queue response FIFO: adds per-channel occupancy, almost-full, held output under backpressure, and sticky overflow reporting.

---
 rtl/tl_d_resp_arb_fifo.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/tl_d_resp_arb_fifo.sv
// tl_d_resp_arb_fifo: multi-channel TileLink D-channel response buffer.
// NUM_CH independent FIFOs (DEPTH entries each) are merged onto one D-channel
// output by a round-robin (ARB_MODE 0) or fixed-priority (ARB_MODE 1) arbiter.
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   in_req       per-channel response beat
//   enq_valid    per-channel push request
//   enq_ready    per-channel FIFO not full
//   almost_full  per-channel level >= AF_THRESH
//   level        per-channel occupancy, channel k at [k*LW +: LW]
//   d_valid      output beat available
//   d_ready      downstream accepts beat
//   out_req      head entry of the granted channel ('0 when idle)
//   out_ch       index of the granted channel
//   ovf_err      sticky per-channel overflow (push while full)
//   clr_err      synchronous clear of ovf_err

package tl_d_pkg;
  typedef struct packed {
    logic [2:0]  d_opcode;
    logic [2:0]  d_param;
    logic [1:0]  d_size;
    logic [7:0]  d_source;
    logic        d_sink;
    logic        d_denied;
    logic [31:0] d_data;
    logic        d_corrupt;
  } tl_d_channel;
endpackage

module tl_d_resp_arb_fifo
  import tl_d_pkg::*;
#(
  parameter int NUM_CH    = 2,
  parameter int DEPTH     = 4,
  parameter int AF_THRESH = DEPTH - 1,
  parameter int ARB_MODE  = 0,
  localparam int LW = $clog2(DEPTH) + 1,
  localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  tl_d_channel          in_req [NUM_CH],
  input  logic [NUM_CH-1:0]    enq_valid,
  output logic [NUM_CH-1:0]    enq_ready,
  output logic [NUM_CH-1:0]    almost_full,
  output logic [NUM_CH*LW-1:0] level,
  output logic                 d_valid,
  input  logic                 d_ready,
  output tl_d_channel          out_req,
  output logic [CW-1:0]        out_ch,
  output logic [NUM_CH-1:0]    ovf_err,
  input  logic                 clr_err
);

  localparam int PW = $clog2(DEPTH);

  tl_d_channel       mem    [NUM_CH][DEPTH];
  logic [PW-1:0]     wr_ptr [NUM_CH];
  logic [PW-1:0]     rd_ptr [NUM_CH];
  logic [LW-1:0]     lvl    [NUM_CH];
  logic [NUM_CH-1:0] non_empty;
  logic [NUM_CH-1:0] push;
  logic [NUM_CH-1:0] pop;
  logic [CW-1:0]     rr_ptr;
  logic [CW-1:0]     locked_ch;
  logic [CW-1:0]     grant;
  logic [CW-1:0]     rr_next;
  logic              lock;
  logic              hs;

  // Channel index addition modulo NUM_CH.
  function automatic logic [CW-1:0] wrap_add(input logic [CW-1:0] a, input int b);
    int s;
    s = int'(a) + b;
    if (s >= NUM_CH) s = s - NUM_CH;
    return CW'(s);
  endfunction

  always_comb begin
    for (int k = 0; k < NUM_CH; k++) begin
      non_empty[k]          = (lvl[k] != '0);
      enq_ready[k]          = (lvl[k] != LW'(DEPTH));
      almost_full[k]        = (int'(lvl[k]) >= AF_THRESH);
      level[k*LW +: LW]     = lvl[k];
    end
  end

  // Grant: a stalled beat keeps its channel; otherwise search the requesters.
  // Loops run downward so the lowest search offset is the final winner.
  always_comb begin
    grant = '0;
    if (lock) begin
      grant = locked_ch;
    end else if (ARB_MODE == 1) begin
      for (int i = NUM_CH - 1; i >= 0; i--)
        if (non_empty[i]) grant = CW'(i);
    end else begin
      for (int i = NUM_CH - 1; i >= 0; i--)
        if (non_empty[wrap_add(rr_ptr, i)]) grant = wrap_add(rr_ptr, i);
    end
  end

  assign d_valid = |non_empty;
  assign hs      = d_valid && d_ready;
  assign out_req = d_valid ? mem[grant][rd_ptr[grant]] : '0;
  assign out_ch  = grant;
  assign rr_next = wrap_add(grant, 1);

  always_comb begin
    for (int k = 0; k < NUM_CH; k++) begin
      push[k] = enq_valid[k] && enq_ready[k];
      pop[k]  = hs && (grant == CW'(k));
    end
  end

  // Storage carries no reset; levels gate every read.
  always_ff @(posedge clk) begin
    for (int k = 0; k < NUM_CH; k++)
      if (push[k]) mem[k][wr_ptr[k]] <= in_req[k];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_CH; k++) begin
        wr_ptr[k] <= '0;
        rd_ptr[k] <= '0;
        lvl[k]    <= '0;
      end
      ovf_err   <= '0;
      rr_ptr    <= '0;
      lock      <= 1'b0;
      locked_ch <= '0;
    end else begin
      for (int k = 0; k < NUM_CH; k++) begin
        if (push[k]) wr_ptr[k] <= wr_ptr[k] + 1'b1;
        if (pop[k])  rd_ptr[k] <= rd_ptr[k] + 1'b1;
        case ({push[k], pop[k]})
          2'b10:   lvl[k] <= lvl[k] + 1'b1;
          2'b01:   lvl[k] <= lvl[k] - 1'b1;
          default: lvl[k] <= lvl[k];
        endcase
        // A new overflow wins over a same-cycle clear.
        if (enq_valid[k] && !enq_ready[k]) ovf_err[k] <= 1'b1;
        else if (clr_err)                  ovf_err[k] <= 1'b0;
      end
      if (hs) begin
        lock <= 1'b0;
        if (ARB_MODE == 0) rr_ptr <= rr_next;
      end else if (d_valid) begin
        lock      <= 1'b1;
        locked_ch <= grant;
      end
    end
  end

endmodule
